forward_hazard_unit: RTL and testbench

// - Producer end of the EX-stage forwarding/flush interface. Generates FA/FB mux selects, load-use stall and branch flush.
// - Sits beside the ID/EX boundary. Keeps a shadow copy of in-flight writer info (EX, MEM, WB).
// - Compares decode-stage sources against that copy; registers the selects so they are valid when the instruction is in EX.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/forward_hazard_unit_sat_counter.sv | 18 +
 rtl/forward_hazard_unit.sv | 102 ++++++++++
 tb/tb_forward_hazard_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and match helpers for the EX-stage forwarding/hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        FLUSH
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       regwrite;
        logic       memtoreg;
    } shadow_entry_t;

    localparam shadow_entry_t BUBBLE = '0;

    // $0 is hardwired to zero, so it never produces a forwardable value.
    function automatic logic entry_match(input shadow_entry_t e, input logic [4:0] src);
        return e.valid && e.regwrite && (e.dest == src) && (src != 5'd0);
    endfunction

    function automatic fwd_sel_t fwd_select(input shadow_entry_t ex_e,
                                            input shadow_entry_t mem_e,
                                            input logic [4:0]    src);
        if (entry_match(ex_e, src))
            return FWD_EX_MEM;
        if (entry_match(mem_e, src))
            return FWD_MEM_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_hazard_unit_sat_counter.sv
// Saturating event counter: counts up on inc, holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding-select, load-use stall and branch-flush generator that shadows
// the EX/MEM/WB writers and registers FA/FB for the instruction entering EX.
import hazard_pkg::*;

module forward_hazard_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ip_valid_ID,
    input  logic [4:0]       ip_rs_ID,
    input  logic [4:0]       ip_rt_ID,
    input  logic             ip_uses_rt_ID,
    input  logic [4:0]       ip_dest_reg_ID,
    input  logic             ip_RegWrite_ID,
    input  logic             ip_MemtoReg_ID,
    input  logic             ip_branch_MEM,
    input  logic             ip_zero_MEM,
    output logic [1:0]       op_FA,
    output logic [1:0]       op_FB,
    output logic             op_stall,
    output logic             op_flush,
    output logic [CNT_W-1:0] op_stall_count,
    output logic [CNT_W-1:0] op_flush_count
);

    // Index 0 = EX, 1 = MEM, 2 = WB.
    shadow_entry_t shadow [3];
    shadow_entry_t decode_entry;
    hz_state_t     state;
    hz_state_t     state_next;
    fwd_sel_t      fa_q;
    fwd_sel_t      fb_q;
    fwd_sel_t      fa_d;
    fwd_sel_t      fb_d;
    logic          load_use;

    always_comb begin
        op_flush = ip_branch_MEM & ip_zero_MEM;

        load_use = shadow[0].memtoreg &&
                   (entry_match(shadow[0], ip_rs_ID) ||
                    (ip_uses_rt_ID && entry_match(shadow[0], ip_rt_ID)));
        op_stall = load_use && (state == RUN) && !op_flush;

        fa_d = FWD_RF;
        fb_d = FWD_RF;
        if (!op_flush) begin
            fa_d = fwd_select(shadow[0], shadow[1], ip_rs_ID);
            if (ip_uses_rt_ID)
                fb_d = fwd_select(shadow[0], shadow[1], ip_rt_ID);
        end

        decode_entry = '{valid:    1'b1,
                         dest:     ip_dest_reg_ID,
                         regwrite: ip_RegWrite_ID,
                         memtoreg: ip_MemtoReg_ID};

        state_next = RUN;
        unique case (state)
            RUN:        state_next = op_flush ? FLUSH : (op_stall ? LOAD_STALL : RUN);
            LOAD_STALL: state_next = op_flush ? FLUSH : RUN;
            FLUSH:      state_next = op_flush ? FLUSH : RUN;
            default:    state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RUN;
            fa_q   <= FWD_RF;
            fb_q   <= FWD_RF;
            shadow <= '{default: BUBBLE};
        end else begin
            state     <= state_next;
            fa_q      <= fa_d;
            fb_q      <= fb_d;
            shadow[2] <= shadow[1];
            // A taken branch kills both the instruction in EX and the one in ID.
            shadow[1] <= op_flush ? BUBBLE : shadow[0];
            shadow[0] <= (ip_valid_ID && !op_stall && !op_flush) ? decode_entry : BUBBLE;
        end
    end

    assign op_FA = fa_q;
    assign op_FB = fb_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_count (
        .clock (clock),
        .reset (reset),
        .inc   (op_stall),
        .count (op_stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_count (
        .clock (clock),
        .reset (reset),
        .inc   (op_flush),
        .count (op_flush_count)
    );

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed pipeline scenarios plus
// randomized traffic against an instruction-history reference model.
module tb_forward_hazard_unit;

    localparam int unsigned CW   = 4;
    localparam int          SMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          ip_valid_ID;
    logic [4:0]    ip_rs_ID;
    logic [4:0]    ip_rt_ID;
    logic          ip_uses_rt_ID;
    logic [4:0]    ip_dest_reg_ID;
    logic          ip_RegWrite_ID;
    logic          ip_MemtoReg_ID;
    logic          ip_branch_MEM;
    logic          ip_zero_MEM;
    logic [1:0]    op_FA;
    logic [1:0]    op_FB;
    logic          op_stall;
    logic          op_flush;
    logic [CW-1:0] op_stall_count;
    logic [CW-1:0] op_flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    forward_hazard_unit #(.CNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .ip_valid_ID    (ip_valid_ID),
        .ip_rs_ID       (ip_rs_ID),
        .ip_rt_ID       (ip_rt_ID),
        .ip_uses_rt_ID  (ip_uses_rt_ID),
        .ip_dest_reg_ID (ip_dest_reg_ID),
        .ip_RegWrite_ID (ip_RegWrite_ID),
        .ip_MemtoReg_ID (ip_MemtoReg_ID),
        .ip_branch_MEM  (ip_branch_MEM),
        .ip_zero_MEM    (ip_zero_MEM),
        .op_FA          (op_FA),
        .op_FB          (op_FB),
        .op_stall       (op_stall),
        .op_flush       (op_flush),
        .op_stall_count (op_stall_count),
        .op_flush_count (op_flush_count)
    );

    // Reference model: the last two issued instructions (distance 1 and 2)
    // plus whether the previous cycle was already a stall or flush cycle.
    bit         m_v   [2];
    logic [4:0] m_dst [2];
    bit         m_rw  [2];
    bit         m_mtr [2];
    bit         m_hold;
    logic [1:0] m_fa;
    logic [1:0] m_fb;
    int         m_sc;
    int         m_fc;

    function automatic bit m_hit(int d, logic [4:0] r);
        return m_v[d] && m_rw[d] && (m_dst[d] == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] m_sel(logic [4:0] r);
        if (m_hit(0, r)) return 2'b10;
        if (m_hit(1, r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_flush();
        return ip_branch_MEM && ip_zero_MEM;
    endfunction

    function automatic bit m_stall();
        return !m_flush() && !m_hold && m_v[0] && m_mtr[0] &&
               (m_hit(0, ip_rs_ID) || (ip_uses_rt_ID && m_hit(0, ip_rt_ID)));
    endfunction

    task automatic tick();
        bit         f;
        bit         s;
        bit         nv;
        logic [4:0] nd;
        bit         nrw;
        bit         nmtr;
        logic [1:0] fa;
        logic [1:0] fb;
        f    = m_flush();
        s    = m_stall();
        fa   = f ? 2'b00 : m_sel(ip_rs_ID);
        fb   = (f || !ip_uses_rt_ID) ? 2'b00 : m_sel(ip_rt_ID);
        nv   = ip_valid_ID && !s && !f;
        nd   = ip_dest_reg_ID;
        nrw  = ip_RegWrite_ID;
        nmtr = ip_MemtoReg_ID;
        @(posedge clock);
        #1;
        if (reset) begin
            m_v    = '{0, 0};
            m_hold = 0;
            m_fa   = 2'b00;
            m_fb   = 2'b00;
            m_sc   = 0;
            m_fc   = 0;
        end else begin
            m_fa     = fa;
            m_fb     = fb;
            m_v[1]   = m_v[0] && !f;
            m_dst[1] = m_dst[0];
            m_rw[1]  = m_rw[0];
            m_mtr[1] = m_mtr[0];
            m_v[0]   = nv;
            m_dst[0] = nd;
            m_rw[0]  = nrw;
            m_mtr[0] = nmtr;
            if (s && m_sc < SMAX) m_sc++;
            if (f && m_fc < SMAX) m_fc++;
            m_hold = s || f;
        end
    endtask

    task automatic set_id(bit v, logic [4:0] rs, logic [4:0] rt, bit urt,
                          logic [4:0] dest, bit rw, bit mtr);
        ip_valid_ID    = v;
        ip_rs_ID       = rs;
        ip_rt_ID       = rt;
        ip_uses_rt_ID  = urt;
        ip_dest_reg_ID = dest;
        ip_RegWrite_ID = rw;
        ip_MemtoReg_ID = mtr;
        #1;
    endtask

    task automatic set_br(bit b, bit z);
        ip_branch_MEM = b;
        ip_zero_MEM   = z;
        #1;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0);
        set_br(0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (op_FA !== 2'b00) begin errors++; $display("FAIL reset_FA got %b want 00", op_FA); end
        if (op_FB !== 2'b00) begin errors++; $display("FAIL reset_FB got %b want 00", op_FB); end
        if (op_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", op_stall); end
        if (op_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", op_flush); end
        if (op_stall_count !== '0) begin errors++; $display("FAIL reset_stall_count got %0d want 0", op_stall_count); end
        if (op_flush_count !== '0) begin errors++; $display("FAIL reset_flush_count got %0d want 0", op_flush_count); end
    endtask

    task automatic test_ex_forward();
        do_reset();
        set_id(1, 1, 2, 1, 3, 1, 0); tick();   // add $3,$1,$2
        set_id(1, 3, 5, 1, 4, 1, 0); tick();   // sub $4,$3,$5
        checks += 2;
        if (op_FA !== 2'b10) begin errors++; $display("FAIL ex_fwd_FA got %b want 10", op_FA); end
        if (op_FB !== 2'b00) begin errors++; $display("FAIL ex_fwd_FB got %b want 00", op_FB); end
    endtask

    task automatic test_mem_forward();
        do_reset();
        set_id(1, 1, 2, 1, 3, 1, 0); tick();   // add $3,$1,$2
        set_id(1, 0, 0, 1, 0, 1, 0); tick();   // nop
        set_id(1, 7, 3, 1, 6, 1, 0); tick();   // or $6,$7,$3
        checks += 2;
        if (op_FA !== 2'b00) begin errors++; $display("FAIL mem_fwd_FA got %b want 00", op_FA); end
        if (op_FB !== 2'b01) begin errors++; $display("FAIL mem_fwd_FB got %b want 01", op_FB); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 2, 0, 2, 1, 1); tick();   // lw $2,0($0)
        set_id(1, 2, 2, 1, 4, 1, 0);           // add $4,$2,$2
        checks += 1;
        if (op_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_first got %b want 1", op_stall); end
        tick();
        checks += 1;
        if (op_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_second got %b want 0", op_stall); end
        tick();
        checks += 3;
        if (op_FA !== 2'b01) begin errors++; $display("FAIL lu_FA got %b want 01", op_FA); end
        if (op_FB !== 2'b01) begin errors++; $display("FAIL lu_FB got %b want 01", op_FB); end
        if (op_stall_count !== CW'(1)) begin errors++; $display("FAIL lu_stall_count got %0d want 1", op_stall_count); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(1, 1, 1, 1, 0, 1, 0); tick();   // add $0,$1,$1
        set_id(1, 0, 0, 1, 5, 1, 0); tick();   // add $5,$0,$0
        checks += 2;
        if (op_FA !== 2'b00) begin errors++; $display("FAIL zero_FA got %b want 00", op_FA); end
        if (op_FB !== 2'b00) begin errors++; $display("FAIL zero_FB got %b want 00", op_FB); end
    endtask

    task automatic test_rt_dest();
        do_reset();
        set_id(1, 8, 8, 0, 8, 1, 0); tick();   // addi $8,$8,1
        set_id(1, 8, 8, 0, 8, 1, 0); tick();   // addi $8,$8,1
        checks += 2;
        if (op_FA !== 2'b10) begin errors++; $display("FAIL addi_FA got %b want 10", op_FA); end
        if (op_FB !== 2'b00) begin errors++; $display("FAIL addi_FB got %b want 00", op_FB); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_id(1, 0, 2, 0, 2, 1, 1); tick();   // lw $2,0($0)
        set_id(1, 2, 2, 1, 4, 1, 0);           // dependent add, load-use pending
        set_br(1, 1);
        checks += 2;
        if (op_flush !== 1'b1) begin errors++; $display("FAIL fl_flush got %b want 1", op_flush); end
        if (op_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", op_stall); end
        tick();
        set_br(0, 0);
        checks += 4;
        if (op_FA !== 2'b00) begin errors++; $display("FAIL fl_FA got %b want 00", op_FA); end
        if (op_FB !== 2'b00) begin errors++; $display("FAIL fl_FB got %b want 00", op_FB); end
        if (op_flush_count !== CW'(1)) begin errors++; $display("FAIL fl_flush_count got %0d want 1", op_flush_count); end
        if (op_stall_count !== '0) begin errors++; $display("FAIL fl_stall_count got %0d want 0", op_stall_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < SMAX + 5; i++) begin
            set_id(1, 0, 2, 0, 2, 1, 1); tick();
            set_id(1, 2, 2, 1, 4, 1, 0); tick(); tick();
        end
        checks += 1;
        if (op_stall_count !== '1) begin errors++; $display("FAIL sat_stall_count got %0d want %0d", op_stall_count, SMAX); end
        set_id(0, 0, 0, 0, 0, 0, 0);
        set_br(1, 1);
        for (int i = 0; i < SMAX + 5; i++) tick();
        set_br(0, 0);
        checks += 1;
        if (op_flush_count !== '1) begin errors++; $display("FAIL sat_flush_count got %0d want %0d", op_flush_count, SMAX); end
    endtask

    task automatic test_random();
        bit b;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            b = ($urandom_range(15) == 0);
            ip_branch_MEM = b;
            ip_zero_MEM   = b ? 1'b1 : 1'($urandom_range(1));
            set_id(1'($urandom_range(7) != 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
                   1'($urandom_range(1)), 5'($urandom_range(3)),
                   1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0));
            checks += 2;
            if (op_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", n, op_stall, m_stall()); end
            if (op_flush !== m_flush()) begin errors++; $display("FAIL rnd_flush cyc %0d got %b want %b", n, op_flush, m_flush()); end
            tick();
            checks += 4;
            if (op_FA !== m_fa) begin errors++; $display("FAIL rnd_FA cyc %0d got %b want %b", n, op_FA, m_fa); end
            if (op_FB !== m_fb) begin errors++; $display("FAIL rnd_FB cyc %0d got %b want %b", n, op_FB, m_fb); end
            if (op_stall_count !== CW'(m_sc)) begin errors++; $display("FAIL rnd_stall_count cyc %0d got %0d want %0d", n, op_stall_count, m_sc); end
            if (op_flush_count !== CW'(m_fc)) begin errors++; $display("FAIL rnd_flush_count cyc %0d got %0d want %0d", n, op_flush_count, m_fc); end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0);
        set_br(0, 0);
        @(negedge clock);
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_zero_reg();
        test_rt_dest();
        test_flush_priority();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
